// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: decode-stage immediate generator for RV32I/RV64I.
// The instruction word is decoded combinationally on the input side and the
// result is captured into a two-entry (OUT + SKID) elastic buffer. Because
// in_ready depends only on registered state, decode and execute stay decoupled
// under backpressure. A flush (branch redirect) empties both entries in one cycle.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       imm_src,
  input  logic [31:0]      instruction,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm_ext,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);

  // Only the two RISC-V register widths have a defined immediate encoding.
  generate
    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
      $fatal(1, "imm_gen_pipe: XLEN must be 32 or 64");
    end
  endgenerate

  typedef enum logic [2:0] {
    SRC_I     = 3'b000,
    SRC_S     = 3'b001,
    SRC_B     = 3'b010,
    SRC_U     = 3'b011,
    SRC_J     = 3'b100,
    SRC_SHAMT = 3'b101,
    SRC_ZIMM  = 3'b110,
    SRC_RSVD  = 3'b111
  } imm_src_e;

  // One buffered result: everything execute needs about the instruction.
  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] tag;
    logic             illegal;
  } entry_t;

  imm_src_e src;
  entry_t   in_entry;
  entry_t   out_entry;
  entry_t   skid_entry;
  logic     skid_valid;

  logic accept;
  logic drain;
  logic load_out_from_in;
  logic load_out_from_skid;
  logic load_skid;

  // The opcode field never contributes to an immediate.
  logic unused_opcode;
  assign unused_opcode = ^instruction[6:0];

  assign src = imm_src_e'(imm_src);

  // Decode the raw instruction into the entry that would be stored on accept.
  always_comb begin
    // NOTE: every field gets a default before the case so no path through the
    // block leaves a value unassigned, which would otherwise infer a latch.
    in_entry     = '0;
    in_entry.tag = in_tag;
    case (src)
      SRC_I:     in_entry.imm = XLEN'($signed(instruction[31:20]));
      SRC_S:     in_entry.imm = XLEN'($signed({instruction[31:25], instruction[11:7]}));
      SRC_B:     in_entry.imm = XLEN'($signed({instruction[31], instruction[7],
                                               instruction[30:25], instruction[11:8], 1'b0}));
      SRC_U:     in_entry.imm = XLEN'($signed({instruction[31:12], 12'b0}));
      SRC_J:     in_entry.imm = XLEN'($signed({instruction[31], instruction[19:12],
                                               instruction[20], instruction[30:21], 1'b0}));
      SRC_SHAMT: in_entry.imm = (XLEN == 64) ? XLEN'(instruction[25:20])
                                             : XLEN'(instruction[24:20]);
      SRC_ZIMM:  in_entry.imm = XLEN'(instruction[19:15]);
      default:   in_entry.illegal = 1'b1;
    endcase
  end

  // Ready is a function of stored state only (plus reset), never of out_ready.
  assign in_ready = !skid_valid && !rst;
  assign accept   = in_valid && in_ready;
  assign drain    = out_valid && out_ready;

  // Steer each accepted or skidded entry to its destination register.
  always_comb begin
    load_out_from_skid = skid_valid && drain;
    load_out_from_in   = accept && (!out_valid || drain);
    load_skid          = accept && out_valid && !drain;
  end

  // Occupancy of the two storage slots; reset and flush discard everything.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst || flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else begin
      if (load_out_from_skid || load_out_from_in) begin
        out_valid <= 1'b1;
      end else if (drain) begin
        out_valid <= 1'b0;
      end
      if (load_skid) begin
        skid_valid <= 1'b1;
      end else if (load_out_from_skid) begin
        skid_valid <= 1'b0;
      end
    end
  end

  // Presented entry: the skid entry has priority because it is older.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_entry <= '0;
    end else if (!flush) begin
      if (load_out_from_skid) begin
        out_entry <= skid_entry;
      end else if (load_out_from_in) begin
        out_entry <= in_entry;
      end
    end
  end

  // Skid payload captures the incoming entry while OUT is stalled.
  always_ff @(posedge clk) begin
    // NOTE: payload storage is not reset; skid_valid alone says whether it
    // holds anything, so clearing the data would only add reset fan-out.
    if (load_skid && !flush) begin
      skid_entry <= in_entry;
    end
  end

  assign imm_ext     = out_entry.imm;
  assign out_tag     = out_entry.tag;
  assign out_illegal = out_entry.illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Testbench for imm_gen_pipe. Two instances (XLEN=32 and XLEN=64) share one
// input stream. A queue-based FIFO model predicts the handshake and an
// arithmetic decoder predicts the immediates; every cycle is compared.
module tb_imm_gen_pipe;

  localparam int TAG_W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic             flush;
  logic             in_valid;
  logic             out_ready;
  logic [2:0]       imm_src;
  logic [31:0]      instruction;
  logic [TAG_W-1:0] in_tag;

  logic             in_ready32, out_valid32, illegal32;
  logic [31:0]      imm32;
  logic [TAG_W-1:0] tag32;
  logic             in_ready64, out_valid64, illegal64;
  logic [63:0]      imm64;
  logic [TAG_W-1:0] tag64;

  imm_gen_pipe #(.XLEN(32), .TAG_W(TAG_W)) u_dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
    .imm_src(imm_src), .instruction(instruction), .in_tag(in_tag),
    .out_valid(out_valid32), .out_ready(out_ready), .imm_ext(imm32),
    .out_tag(tag32), .out_illegal(illegal32)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(TAG_W)) u_dut64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
    .imm_src(imm_src), .instruction(instruction), .in_tag(in_tag),
    .out_valid(out_valid64), .out_ready(out_ready), .imm_ext(imm64),
    .out_tag(tag64), .out_illegal(illegal64)
  );

  int vectors     = 0;
  int miscompares = 0;
  bit check_en    = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decoder: arithmetic on the sign-extended instruction word.
  function automatic logic [63:0] ref_imm(input logic [31:0] ins, input logic [2:0] s_sel,
                                          input bit x64);
    longint      s;
    longint      sgn;
    longint      hi;
    logic [63:0] r;
    s   = longint'(signed'(ins));
    sgn = s >>> 31;
    case (s_sel)
      3'd0: begin hi = s >>> 20; r = hi; end
      3'd1: begin hi = s >>> 25; r = (hi <<< 5) | 64'(ins[11:7]); end
      3'd2: r = (sgn << 12) | (64'(ins[7]) << 11) | (64'(ins[30:25]) << 5)
              | (64'(ins[11:8]) << 1);
      3'd3: r = s & ~64'hFFF;
      3'd4: r = (sgn << 20) | (64'(ins[19:12]) << 12) | (64'(ins[20]) << 11)
              | (64'(ins[30:21]) << 1);
      3'd5: r = x64 ? 64'(ins[25:20]) : 64'(ins[24:20]);
      3'd6: r = 64'(ins[19:15]);
      default: r = 64'd0;
    endcase
    return r;
  endfunction

  typedef struct {
    logic [31:0]      instr;
    logic [2:0]       src;
    logic [TAG_W-1:0] tag;
  } txn_t;

  txn_t q[$];

  // Model: a FIFO of at most two entries, cleared by reset or flush.
  always @(posedge clk) begin : model_b
    bit   take;
    bit   give;
    txn_t t;
    if (rst || flush) begin
      q.delete();
    end else begin
      give = (q.size() > 0) && out_ready;
      take = in_valid && (q.size() < 2);
      if (give) void'(q.pop_front());
      if (take) begin
        t.instr = instruction;
        t.src   = imm_src;
        t.tag   = in_tag;
        q.push_back(t);
      end
    end
  end

  // Compare both DUTs against the model on every falling edge.
  always @(negedge clk) begin : cmp_b
    logic [63:0] e;
    bit          ev;
    if (check_en) begin
      ev = q.size() > 0;
      check("out_valid32", 64'(out_valid32), 64'(ev));
      check("out_valid64", 64'(out_valid64), 64'(ev));
      check("in_ready32", 64'(in_ready32), 64'(!rst && q.size() < 2));
      check("in_ready64", 64'(in_ready64), 64'(!rst && q.size() < 2));
      if (ev) begin
        e = ref_imm(q[0].instr, q[0].src, 1'b0);
        check("imm32", 64'(imm32), 64'(e[31:0]));
        e = ref_imm(q[0].instr, q[0].src, 1'b1);
        check("imm64", imm64, e);
        check("tag32", 64'(tag32), 64'(q[0].tag));
        check("tag64", 64'(tag64), 64'(q[0].tag));
        check("illegal32", 64'(illegal32), 64'(q[0].src == 3'b111));
        check("illegal64", 64'(illegal64), 64'(q[0].src == 3'b111));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [31:0] ins, input logic [2:0] s_sel,
                       input logic [TAG_W-1:0] tg);
    in_valid    = v;
    instruction = ins;
    imm_src     = s_sel;
    in_tag      = tg;
  endtask

  initial begin : main_b
    logic [63:0] m;
    logic [31:0] r1, r2, r3;

    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 32'h0, 3'd0, '0);

    // Pin the reference decoder to hand-computed values.
    m = ref_imm(32'hFFF00093, 3'd0, 1'b0); check("pin_i", m, 64'hFFFF_FFFF_FFFF_FFFF);
    m = ref_imm(32'hFE20AE23, 3'd1, 1'b0); check("pin_s", m, 64'hFFFF_FFFF_FFFF_FFFC);
    m = ref_imm(32'hFE000CE3, 3'd2, 1'b0); check("pin_b", m, 64'hFFFF_FFFF_FFFF_FFF8);
    m = ref_imm(32'h123450B7, 3'd3, 1'b1); check("pin_u_pos", m, 64'h0000_0000_1234_5000);
    m = ref_imm(32'h800000B7, 3'd3, 1'b1); check("pin_u_neg", m, 64'hFFFF_FFFF_8000_0000);
    m = ref_imm(32'hFFDFF06F, 3'd4, 1'b0); check("pin_j", m, 64'hFFFF_FFFF_FFFF_FFFC);
    m = ref_imm(32'h03F0D093, 3'd5, 1'b1); check("pin_shamt64", m, 64'h3F);
    m = ref_imm(32'h03F0D093, 3'd5, 1'b0); check("pin_shamt32", m, 64'h1F);
    m = ref_imm(32'h000AD073, 3'd6, 1'b0); check("pin_zimm", m, 64'h15);
    m = ref_imm(32'hFFFFFFFF, 3'd7, 1'b1); check("pin_rsvd", m, 64'h0);

    // Reset values.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready32), 64'd0);
    check("rst_out_valid", 64'(out_valid32), 64'd0);
    check("rst_imm64", imm64, 64'd0);
    check("rst_tag", 64'(tag32), 64'd0);
    check("rst_illegal", 64'(illegal64), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    check_en = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 64'(in_ready32), 64'd1);
    tick();

    // I-type, one-cycle latency.
    out_ready = 1'b1;
    drive(1'b1, 32'hFFF00093, 3'd0, 4'd5);
    tick();
    drive(1'b0, 32'h0, 3'd0, '0);
    @(negedge clk);
    check("i_valid", 64'(out_valid32), 64'd1);
    check("i_imm32", 64'(imm32), 64'hFFFF_FFFF);
    check("i_illegal", 64'(illegal32), 64'd0);
    tick();

    // S then B on consecutive cycles.
    drive(1'b1, 32'hFE20AE23, 3'd1, 4'd1);
    tick();
    drive(1'b1, 32'hFE000CE3, 3'd2, 4'd2);
    @(negedge clk);
    check("s_tag", 64'(tag32), 64'd1);
    check("s_imm32", 64'(imm32), 64'hFFFF_FFFC);
    tick();
    drive(1'b0, 32'h0, 3'd0, '0);
    @(negedge clk);
    check("b_tag", 64'(tag32), 64'd2);
    check("b_imm32", 64'(imm32), 64'hFFFF_FFF8);
    tick();

    // U and SHAMT for both widths.
    drive(1'b1, 32'h123450B7, 3'd3, 4'd3);
    tick();
    drive(1'b1, 32'h800000B7, 3'd3, 4'd4);
    @(negedge clk);
    check("u_pos_imm64", imm64, 64'h0000_0000_1234_5000);
    tick();
    drive(1'b1, 32'h03F0D093, 3'd5, 4'd5);
    @(negedge clk);
    check("u_neg_imm64", imm64, 64'hFFFF_FFFF_8000_0000);
    tick();
    drive(1'b0, 32'h0, 3'd0, '0);
    @(negedge clk);
    check("shamt_imm64", imm64, 64'h3F);
    check("shamt_imm32", 64'(imm32), 64'h1F);
    tick();

    // Backpressure: tag 1 in OUT, tag 2 in SKID, tag 3 held off.
    r1 = $urandom; r2 = $urandom; r3 = $urandom;
    out_ready = 1'b0;
    drive(1'b1, r1, 3'd0, 4'd1);
    tick();
    drive(1'b1, r2, 3'd0, 4'd2);
    tick();
    drive(1'b1, r3, 3'd0, 4'd3);
    m = ref_imm(r1, 3'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_in_ready", 64'(in_ready32), 64'd0);
      check("bp_tag_hold", 64'(tag32), 64'd1);
      check("bp_imm_hold", 64'(imm32), 64'(m[31:0]));
      tick();
    end
    out_ready = 1'b1;
    tick();
    @(negedge clk);
    check("bp_tag2", 64'(tag32), 64'd2);
    check("bp_reaccept_ready", 64'(in_ready32), 64'd1);
    tick();
    drive(1'b0, 32'h0, 3'd0, '0);
    @(negedge clk);
    check("bp_tag3", 64'(tag32), 64'd3);
    tick();
    @(negedge clk);
    check("bp_empty", 64'(out_valid32), 64'd0);
    tick();

    // Flush with both entries full and a new offer pending.
    out_ready = 1'b0;
    drive(1'b1, $urandom, 3'd0, 4'd7);
    tick();
    drive(1'b1, $urandom, 3'd0, 4'd8);
    tick();
    drive(1'b1, $urandom, 3'd0, 4'd9);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 3'd0, '0);
    @(negedge clk);
    check("flush_out_valid", 64'(out_valid32), 64'd0);
    check("flush_in_ready", 64'(in_ready32), 64'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      @(negedge clk);
      check("flush_no_ghost", 64'(out_valid64), 64'd0);
    end
    tick();

    // Reserved format.
    drive(1'b1, 32'hFFFFFFFF, 3'd7, 4'd4);
    tick();
    drive(1'b0, 32'h0, 3'd0, '0);
    @(negedge clk);
    check("rsvd_imm32", 64'(imm32), 64'd0);
    check("rsvd_imm64", imm64, 64'd0);
    check("rsvd_illegal32", 64'(illegal32), 64'd1);
    check("rsvd_illegal64", 64'(illegal64), 64'd1);
    tick();

    // Reset pulsed for one cycle during a stall.
    out_ready = 1'b0;
    drive(1'b1, $urandom, 3'd1, 4'd10);
    tick();
    drive(1'b1, $urandom, 3'd2, 4'd11);
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("rst_stall_in_ready", 64'(in_ready32), 64'd0);
    tick();
    rst = 1'b0;
    drive(1'b0, 32'h0, 3'd0, '0);
    @(negedge clk);
    check("rst_stall_out_valid", 64'(out_valid32), 64'd0);
    check("rst_stall_in_ready_after", 64'(in_ready32), 64'd1);
    tick();

    // Randomized traffic with varying backpressure, occasional flush and reset.
    for (int p = 0; p < 6; p++) begin
      repeat (500) begin
        out_ready   = $urandom_range(0, 9) < (2 + p);
        in_valid    = $urandom_range(0, 3) != 0;
        instruction = $urandom;
        imm_src     = 3'($urandom_range(0, 7));
        in_tag      = TAG_W'($urandom);
        flush       = $urandom_range(0, 39) == 0;
        rst         = $urandom_range(0, 199) == 0;
        tick();
      end
    end
    rst = 1'b0; flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, 32'h0, 3'd0, '0);
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Next-generation immediate generator for the core's decode stage.
- Covers every RV32I/RV64I immediate format plus shift-amount and CSR-uimm forms.
- XLEN is parametrised.
- The result is registered behind a valid/ready handshake with a 2-entry skid buffer, so decode can be decoupled from execute under backpressure and flushed on redirect.

Parameters:
- XLEN, 32, output immediate width; legal values 32 or 64.
- TAG_W, 4, width of the sideband tag carried alongside each instruction (e.g. ROB/PC index).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- flush  input  1  discard all buffered entries (branch redirect).
- in_valid  input  1  upstream has an instruction.
- in_ready  output  1  block can accept this cycle.
- imm_src  input  3  format select: 000 I, 001 S, 010 B, 011 U, 100 J, 101 SHAMT, 110 ZIMM, 111 reserved.
- instruction  input  32  raw instruction word.
- in_tag  input  TAG_W  sideband tag.
- out_valid  output  1  imm_ext/out_tag/out_illegal valid.
- out_ready  input  1  downstream accepts.
- imm_ext  output  XLEN  extended immediate.
- out_tag  output  TAG_W  tag of the presented entry.
- out_illegal  output  1  imm_src was 111.

Behaviour:
- Handshakes:
  - Accept occurs when in_valid && in_ready.
  - Drain occurs when out_valid && out_ready.
- Decode, combinational on the input side, registered on accept. "sext" means sign-extend from instruction[31] to XLEN.
  - I: sext(instr[31:20]).
  - S: sext({instr[31:25],instr[11:7]}).
  - B: sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0}).
  - U: sext({instr[31:12],12'b0}); for XLEN=64 this is sign-extended from bit 31.
  - J: sext({instr[31],instr[19:12],instr[20],instr[30:21],1'b0}).
  - SHAMT: zero-extended instr[24:20] when XLEN=32; instr[25:20] when XLEN=64.
  - ZIMM: zero-extended instr[19:15].
  - 111: imm_ext = 0 and out_illegal = 1. The entry still flows through the handshake.
- Storage is an output register (OUT) plus a skid register (SKID), each with its own valid bit.
- in_ready = !skid_valid && !rst. It is derived only from state, never from out_ready.
- Per-cycle update rules, applied in priority order:
  1. rst or flush: out_valid <= 0, skid_valid <= 0. Any same-cycle accept is discarded.
  2. OUT empty, or OUT draining with SKID empty: an accept loads OUT.
  3. OUT full, not draining, SKID empty: an accept loads SKID; in_ready falls next cycle.
  4. OUT draining with SKID full: SKID moves to OUT and SKID empties. No accept is possible, since in_ready=0.
  5. OUT draining, SKID empty, no accept: out_valid <= 0.
- Latency: an entry accepted in cycle N appears with out_valid=1 in cycle N+1 if OUT was free.
- Throughput: 1 entry/cycle with out_ready held high.
- Ordering is strictly FIFO, and no entry is dropped or duplicated except by flush/rst.
- Outputs are stable while out_valid && !out_ready: imm_ext, out_tag and out_illegal must not change.
- Reset values: out_valid=0, skid_valid=0, in_ready=0 while rst=1 and 1 the cycle after deassert. imm_ext, out_tag and out_illegal are reset to 0.
- Reset or flush asserted mid-stall empties both entries in one cycle; in_ready=1 the following cycle (flush) or after rst deassert.
- A width parameter other than 32/64 is a fatal elaboration error.

Test Plan:
- I-type, XLEN=32: instr 0xFFF00093, src 000, out_ready=1 -> cycle+1 out_valid=1, imm_ext=0xFFFFFFFF, out_illegal=0.
- S and B back-to-back, tags 1 and 2:
  - 0xFE20AE23/src 001 -> 0xFFFFFFFC.
  - 0xFE000CE3/src 010 -> 0xFFFFFFF8.
  - Consecutive cycles, tags 1 then 2.
- U with XLEN=64: 0x123450B7 -> 0x0000000012345000; 0x800000B7 -> 0xFFFFFFFF80000000. Shift with XLEN=64: instr 0x03F0D093 (srli shamt=63), src 101 -> 0x3F.
- Backpressure: out_ready=0, offer tags 1,2,3 every cycle.
  - Tag 1 goes to OUT, tag 2 goes to SKID; in_ready=0 from the next cycle and tag 3 is held.
  - imm_ext stays stable.
  - Raise out_ready: outputs tag 1, then tag 2, then tag 3 in order, with no gaps beyond the re-accept cycle.
- Flush with both entries full and in_valid=1: next cycle out_valid=0, in_ready=1, and the flushed tags never appear.
- Reserved src 111 with instr 0xFFFFFFFF -> imm_ext=0, out_illegal=1. Then rst pulsed for 1 cycle during a stall -> out_valid=0 and in_ready=1 the cycle after rst falls.
